// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register plus a direct-mapped one-word-per-line
// instruction cache, with miss refill through the memory controller.
module if_fetch #(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  INST_LEN   = 32,
    parameter int                  ICACHE_IDX = 7,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                stall_in,
    input  logic                jump_or_not,
    input  logic [ADDR_LEN-1:0] jump_addr,
    output logic [ADDR_LEN-1:0] if_pc,
    output logic [INST_LEN-1:0] if_inst,
    output logic                if_stall,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    input  logic                mem_done,
    input  logic [INST_LEN-1:0] mem_inst
);

    localparam int LINES = 1 << ICACHE_IDX;
    localparam int TAG_W = ADDR_LEN - ICACHE_IDX - 2;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t                state_q;
    logic [ADDR_LEN-1:0]   pc_q;
    logic [ADDR_LEN-1:0]   pc_d;
    logic                  mem_req_q;
    // The outstanding request word address is also the line to refill.
    logic [ADDR_LEN-3:0]   miss_word_q;
    logic [LINES-1:0]      valid_q;

    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [INST_LEN-1:0]   data_mem [LINES];

    logic [ICACHE_IDX-1:0] pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [ICACHE_IDX-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  fill;

    assign pc_idx   = pc_q[ICACHE_IDX+1:2];
    assign pc_tag   = pc_q[ADDR_LEN-1:ICACHE_IDX+2];
    assign fill_idx = miss_word_q[ICACHE_IDX-1:0];
    assign fill_tag = miss_word_q[ADDR_LEN-3:ICACHE_IDX];

    assign hit  = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag) && (state_q == IDLE);
    assign fill = !rst && rdy && (state_q == WAIT_MEM) && mem_done;

    assign if_pc    = pc_q;
    assign if_inst  = hit ? data_mem[pc_idx] : '0;
    assign if_stall = !hit;
    assign mem_req  = mem_req_q;
    assign mem_addr = {miss_word_q, 2'b00};

    // A redirect beats both stall and sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (jump_or_not) begin
            pc_d = jump_addr;
        end else if (hit && !stall_in) begin
            pc_d = pc_q + ADDR_LEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            miss_word_q <= '0;
            valid_q     <= '0;
        end else if (rdy) begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    if (!hit && !jump_or_not) begin
                        state_q     <= WAIT_MEM;
                        mem_req_q   <= 1'b1;
                        miss_word_q <= pc_q[ADDR_LEN-1:2];
                    end
                end
                WAIT_MEM: begin
                    // A redirect never cancels the refill; the word is still valid.
                    if (mem_done) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_req_q         <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_inst;
        end
    end

endmodule
